mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-stage access controller: drives the data memory over a request/acknowledge handshake on behalf of the EX/MEM register. It stalls the upstream pipeline while an access is outstanding and produces the writeback bundle (we, dst_addr, dst_data, hlt) that the MEM/WB register captures. It feeds the MEM/WB register's inputs. Its stall output goes to the PC, IF/ID, ID/EX and EX/MEM registers only; MEM/WB is never stalled by this block.

## Interface
- DATA_W, 16, datapath/address width
- REG_AW, 4, register-file address width
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with MEM_TIMEOUT_EN)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_re  in  1  EX/MEM: load
- mem_we  in  1  EX/MEM: store
- alu_result  in  DATA_W  EX/MEM: address for load/store, result otherwise
- store_data  in  DATA_W  EX/MEM: store data
- we_in  in  1  EX/MEM: register write enable
- dst_addr_in  in  REG_AW  EX/MEM: destination register
- hlt_in  in  1  EX/MEM: halt marker
- flush_mem  in  1  squash current MEM instruction
- dm_req  out  1  memory request, registered
- dm_wr  out  1  1 = write, registered
- dm_addr  out  DATA_W  registered address
- dm_wdata  out  DATA_W  registered write data
- dm_ack  in  1  memory completion, valid only while dm_req = 1
- dm_rdata  in  DATA_W  read data, valid with dm_ack
- we_out  out  1  to MEM/WB
- dst_addr_out  out  REG_AW  to MEM/WB
- dst_data_out  out  DATA_W  to MEM/WB
- hlt_out  out  1  to MEM/WB
- stall_mem  out  1  hold upstream stages
- mem_err  out  1  sticky access-timeout flag

## Operation
- Uses a three-state FSM: IDLE, WAIT, DONE.
- **IDLE**
  - If mem_re|mem_we is set and flush_mem is clear:
    - Register dm_addr = alu_result, dm_wdata = store_data, dm_wr = mem_we.
    - Set dm_req and go to WAIT.
    - Assert stall_mem and drive a bubble.
  - Otherwise, pass through with zero stall:
    - we_out = we_in & ~flush_mem
    - hlt_out = hlt_in & ~flush_mem
    - dst_addr_out = dst_addr_in
    - dst_data_out = alu_result
- **WAIT**
  - dm_req stays 1, with address, data and direction stable.
  - stall_mem = 1; outputs are a bubble.
  - On dm_ack:
    - Clear dm_req.
    - For a load, capture dm_rdata into rdata_q.
    - Go to DONE.
- **DONE**
  - stall_mem = 0.
  - Emit the held instruction's bundle; dst_data_out = rdata_q for a load, alu_result for a store.
  - Return to IDLE unconditionally. EX/MEM advances at this edge.
- **Bubble**: we_out = 0, hlt_out = 0, dst_addr_out = 0, dst_data_out = 0.
- **flush_mem in WAIT**
  - The transaction cannot be cancelled.
  - Set a flushed flag and continue waiting for dm_ack.
  - DONE then emits a bubble. The flag clears on entry to IDLE.
- **flush_mem in DONE**: emits a bubble.
- A store never writes the register file unless we_in is set; this block does not check it.

## Timing
- **Reset values**: state IDLE, dm_req 0, dm_wr 0, dm_addr 0, dm_wdata 0, rdata_q 0, flushed 0, mem_err 0.
  - Combinational outputs follow IDLE with inputs.
- **Memory op cost** = 2 + (memory wait cycles) cycles.
  - Minimum 3 cycles when dm_ack arrives in the first WAIT cycle.
  - stall_mem is high for all cycles but the last.
- **Non-memory op**: 0 extra cycles.
- **Back-to-back memory ops**: the second starts in the IDLE cycle after DONE. No overlap; at most one outstanding request.
- **Reset mid-access**: dm_req drops asynchronously and the result is discarded. The memory is reset by the same rst.
- dm_ack while dm_req = 0 is ignored.

## Configuration
- **MEM_TIMEOUT_EN** defined:
  - A counter runs in WAIT, cleared on WAIT entry.
  - After TIMEOUT_CYCLES WAIT cycles without dm_ack:
    - Drop dm_req.
    - Set mem_err (sticky until rst).
    - Go to DONE, which emits we_out = 0, hlt_out = 1 so the core halts at writeback.
- **Undefined**: WAIT is unbounded, mem_err is tied to 0, and no counter logic exists.

## Structure
- Shared package cpu_pkg:
  - mem_state_t enum (IDLE, WAIT, DONE)
  - DATA_W and REG_AW constants
  - bubble constant for the writeback bundle
- One sub-module: mem_timeout_ctr (load/enable/expire), instantiated only under MEM_TIMEOUT_EN.

## Test plan
- **Non-memory op**: we_in = 1, dst_addr_in = 4'h3, alu_result = 16'h1234 -> same cycle we_out = 1, dst_data_out = 16'h1234, stall_mem = 0.
- **Load, 1-cycle memory**: mem_re, alu_result = 16'h0040, dm_rdata = 16'hBEEF with ack in the first WAIT cycle -> dm_addr = 16'h0040, stall_mem high 2 cycles, DONE shows dst_data_out = 16'hBEEF, we_out = 1.
- **Store, ack after 5 cycles**: dm_wr = 1, dm_wdata stable throughout, stall_mem high 6 cycles, DONE shows we_out = we_in.
- **flush_mem during WAIT**: transaction completes on ack, DONE emits a bubble (we_out = 0), then the next op proceeds normally.
- **rst asserted in WAIT**: dm_req = 0 immediately, state IDLE, a late dm_ack is ignored.
- **MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack**: dm_req drops after 4 WAIT cycles, mem_err = 1, hlt_out = 1, we_out = 0 in DONE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the memory stage.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } mem_state_t;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] dst_addr;
    logic [DATA_W-1:0] dst_data;
    logic              hlt;
  } wb_bundle_t;

  localparam wb_bundle_t WB_BUBBLE = '{we: 1'b0, dst_addr: '0, dst_data: '0, hlt: 1'b0};

endpackage

// File: rtl/mem_timeout_ctr.sv
// WAIT-state cycle counter; expire flags the Limit-th enabled cycle since the last load.
module mem_timeout_ctr #(
  parameter int unsigned Limit = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign expire = enable && (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: one outstanding data-memory request, upstream stall, WB bundle.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int unsigned DATA_W         = cpu_pkg::DATA_W,
  parameter int unsigned REG_AW         = cpu_pkg::REG_AW,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              we_in,
  input  logic [REG_AW-1:0] dst_addr_in,
  input  logic              hlt_in,
  input  logic              flush_mem,
  output logic              dm_req,
  output logic              dm_wr,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              we_out,
  output logic [REG_AW-1:0] dst_addr_out,
  output logic [DATA_W-1:0] dst_data_out,
  output logic              hlt_out,
  output logic              stall_mem,
  output logic              mem_err
);

  import cpu_pkg::*;

  mem_state_t        state_d, state_q;
  logic              dm_req_d, dm_req_q;
  logic              dm_wr_d, dm_wr_q;
  logic [DATA_W-1:0] dm_addr_d, dm_addr_q;
  logic [DATA_W-1:0] dm_wdata_d, dm_wdata_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              flushed_d, flushed_q;
  logic              start;
  logic              done_halt;

  assign start = (state_q == StIdle) && (mem_re || mem_we) && !flush_mem;

`ifdef MEM_TIMEOUT_EN
  logic tmo_expire;
  logic timed_out_d, timed_out_q;
  logic mem_err_d, mem_err_q;

  mem_timeout_ctr #(
    .Limit(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .load  (start),
    .enable(state_q == StWait),
    .expire(tmo_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timed_out_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      timed_out_q <= timed_out_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign done_halt = timed_out_q;
`else
  assign mem_err   = 1'b0;
  assign done_halt = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_wr_d    = dm_wr_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    rdata_d    = rdata_q;
    flushed_d  = flushed_q;
`ifdef MEM_TIMEOUT_EN
    timed_out_d = timed_out_q;
    mem_err_d   = mem_err_q;
`endif
    stall_mem    = 1'b0;
    we_out       = WB_BUBBLE.we;
    hlt_out      = WB_BUBBLE.hlt;
    dst_addr_out = REG_AW'(WB_BUBBLE.dst_addr);
    dst_data_out = DATA_W'(WB_BUBBLE.dst_data);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dm_req_d   = 1'b1;
          dm_wr_d    = mem_we;
          dm_addr_d  = alu_result;
          dm_wdata_d = store_data;
          state_d    = StWait;
          stall_mem  = 1'b1;
        end else begin
          we_out       = we_in && !flush_mem;
          hlt_out      = hlt_in && !flush_mem;
          dst_addr_out = dst_addr_in;
          dst_data_out = alu_result;
        end
      end
      StWait: begin
        stall_mem = 1'b1;
        // The request cannot be withdrawn, so a flush is only remembered.
        if (flush_mem) begin
          flushed_d = 1'b1;
        end
        if (dm_ack) begin
          dm_req_d = 1'b0;
          if (!dm_wr_q) begin
            rdata_d = dm_rdata;
          end
          state_d = StDone;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_expire) begin
          dm_req_d    = 1'b0;
          mem_err_d   = 1'b1;
          timed_out_d = 1'b1;
          state_d     = StDone;
        end
`endif
      end
      StDone: begin
        state_d   = StIdle;
        flushed_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
        timed_out_d = 1'b0;
`endif
        if (done_halt) begin
          hlt_out = 1'b1;
        end else if (!(flushed_q || flush_mem)) begin
          we_out       = we_in;
          hlt_out      = hlt_in;
          dst_addr_out = dst_addr_in;
          dst_data_out = dm_wr_q ? alu_result : rdata_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      dm_req_q   <= 1'b0;
      dm_wr_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rdata_q    <= '0;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_wr_q    <= dm_wr_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      rdata_q    <= rdata_d;
      flushed_q  <= flushed_d;
    end
  end

  assign dm_req   = dm_req_q;
  assign dm_wr    = dm_wr_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;

endmodule
